// File: rtl/spi_flash_seq.sv
// Flash-read sequencer sharing the spi master register port with the CPU.
// Owns the port for READ command + address, streams words out on valid/ready, then hands back.
module spi_flash_seq #(
   parameter logic [7:0]  CMD   = 8'h03,
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [23:0]      flash_addr,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic [3:0]       cpu_we,
   input  logic             cpu_rd,
   input  logic             cpu_select,
   input  logic [1:0]       cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_wbusy,
   output logic             cpu_rbusy,
   output logic [3:0]       spi_we,
   output logic             spi_rd,
   output logic             spi_select,
   output logic [1:0]       spi_addr,
   output logic [31:0]      spi_wdata,
   input  logic [31:0]      spi_rdata,
   input  logic             spi_wbusy,
   input  logic             spi_rbusy
);

   typedef enum logic [3:0] {
      StIdle, StWaitCpu, StCtrl, StCmd, StDummy, StRead, StPush, StRelease, StDone
   } state_e;

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             owner_q, owner_d;
   logic [23:0]      addr_q, addr_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             abort_q, abort_d;
   logic             phase_q, phase_d;
   logic             hold_q, hold_d;
   logic [31:0]      out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       s_we_q, s_we_d;
   logic             s_rd_q, s_rd_d;
   logic             s_sel_q, s_sel_d;
   logic [1:0]       s_addr_q, s_addr_d;
   logic [31:0]      s_wdata_q, s_wdata_d;
   logic             complete;

   // A read access is complete once the strobe has been up for two cycles and the master is idle.
   assign complete = s_rd_q & hold_q & ~spi_rbusy;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      owner_d     = owner_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      abort_d     = abort_q;
      phase_d     = phase_q;
      hold_d      = s_rd_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      s_we_d      = s_we_q;
      s_rd_d      = s_rd_q;
      s_sel_d     = s_sel_q;
      s_addr_d    = s_addr_q;
      s_wdata_d   = s_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = flash_addr;
               cnt_d   = len;
               busy_d  = 1'b1;
               state_d = StWaitCpu;
            end
         end
         StWaitCpu: begin
            if (!cpu_select) begin
               owner_d   = 1'b1;
               s_sel_d   = 1'b1;
               s_we_d    = 4'b1111;
               s_addr_d  = 2'd2;
               s_wdata_d = 32'h0101_0003;
               state_d   = StCtrl;
            end
         end
         StCtrl: begin
            s_addr_d  = 2'd1;
            s_wdata_d = {CMD, addr_q};
            state_d   = StCmd;
         end
         StCmd: begin
            s_we_d    = 4'b0000;
            s_rd_d    = 1'b1;
            s_addr_d  = 2'd0;
            s_wdata_d = 32'h0;
            state_d   = StDummy;
         end
         StDummy: begin
            if (complete) begin
               s_rd_d  = 1'b0;
               s_sel_d = 1'b0;
               phase_d = 1'b0;
               state_d = (cnt_q != '0 && !abort) ? StRead : StRelease;
            end
         end
         StRead: begin
            if (!phase_q) begin
               s_sel_d  = 1'b1;
               s_rd_d   = 1'b1;
               s_addr_d = 2'd0;
               phase_d  = 1'b1;
            end else if (complete) begin
               s_rd_d      = 1'b0;
               s_sel_d     = 1'b0;
               out_data_d  = spi_rdata;
               out_valid_d = 1'b1;
               abort_d     = abort;
               state_d     = StPush;
            end
         end
         StPush: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = cnt_q - LEN_W'(1);
               phase_d     = 1'b0;
               state_d     = (cnt_q == LEN_W'(1) || abort_q) ? StRelease : StRead;
            end
         end
         StRelease: begin
            if (!phase_q) begin
               // Only the top byte is written, clearing ss_active and leaving the rest alone.
               s_sel_d   = 1'b1;
               s_we_d    = 4'b1000;
               s_addr_d  = 2'd2;
               s_wdata_d = 32'h0001_0003;
               phase_d   = 1'b1;
            end else begin
               s_sel_d = 1'b0;
               s_we_d  = 4'b0000;
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            owner_d = 1'b0;
            busy_d  = 1'b0;
            phase_d = 1'b0;
            abort_d = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         owner_q     <= 1'b0;
         addr_q      <= 24'h0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         phase_q     <= 1'b0;
         hold_q      <= 1'b0;
         out_data_q  <= 32'h0;
         out_valid_q <= 1'b0;
         s_we_q      <= 4'b0000;
         s_rd_q      <= 1'b0;
         s_sel_q     <= 1'b0;
         s_addr_q    <= 2'd0;
         s_wdata_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         phase_q     <= phase_d;
         hold_q      <= hold_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         s_we_q      <= s_we_d;
         s_rd_q      <= s_rd_d;
         s_sel_q     <= s_sel_d;
         s_addr_q    <= s_addr_d;
         s_wdata_q   <= s_wdata_d;
      end
   end

   // Port mux: while the sequencer owns the port, CPU accesses see busy and never reach the master.
   always_comb begin
      if (owner_q) begin
         spi_we     = s_we_q;
         spi_rd     = s_rd_q;
         spi_select = s_sel_q;
         spi_addr   = s_addr_q;
         spi_wdata  = s_wdata_q;
         cpu_rdata  = 32'h0;
         cpu_wbusy  = cpu_select & (cpu_we != 4'b0000);
         cpu_rbusy  = cpu_select & cpu_rd;
      end else begin
         spi_we     = cpu_we;
         spi_rd     = cpu_rd;
         spi_select = cpu_select;
         spi_addr   = cpu_addr;
         spi_wdata  = cpu_wdata;
         cpu_rdata  = spi_rdata;
         cpu_wbusy  = spi_wbusy;
         cpu_rbusy  = spi_rbusy;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a behavioural spi master / flash model and a word scoreboard.
module tb_spi_flash_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, abort, out_ready;
   logic [23:0] flash_addr;
   logic [15:0] len;
   logic        busy, done, out_valid;
   logic [31:0] out_data;
   logic [3:0]  cpu_we;
   logic        cpu_rd, cpu_select;
   logic [1:0]  cpu_addr;
   logic [31:0] cpu_wdata, cpu_rdata;
   logic        cpu_wbusy, cpu_rbusy;
   logic [3:0]  spi_we;
   logic        spi_rd, spi_select;
   logic [1:0]  spi_addr;
   logic [31:0] spi_wdata, spi_rdata;
   logic        spi_wbusy, spi_rbusy;

   always #5 clk = ~clk;

   spi_flash_seq dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .flash_addr (flash_addr),
      .len        (len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .cpu_we     (cpu_we),
      .cpu_rd     (cpu_rd),
      .cpu_select (cpu_select),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_wbusy  (cpu_wbusy),
      .cpu_rbusy  (cpu_rbusy),
      .spi_we     (spi_we),
      .spi_rd     (spi_rd),
      .spi_select (spi_select),
      .spi_addr   (spi_addr),
      .spi_wdata  (spi_wdata),
      .spi_rdata  (spi_rdata),
      .spi_wbusy  (spi_wbusy),
      .spi_rbusy  (spi_rbusy)
   );

   function automatic logic [31:0] flash_word(input logic [23:0] a);
      if (a == 24'h001000) return 32'hDEAD_BEEF;
      if (a == 24'h001004) return 32'h0123_4567;
      return {a[15:0], 8'hA5, a[23:16]} ^ 32'h3C3C_0F0F;
   endfunction

   // spi master + flash model: a read access runs one 32-bit transfer shifting out the IMMDATA reg.
   logic [31:0] m_ctrl, m_imm, m_rdata, m_res, m_cmd;
   logic [23:0] m_faddr;
   logic        m_busy, m_served;
   int          m_cnt, m_xfers, m_idx;
   logic [3:0]  m_ss;

   assign m_ss      = m_ctrl[24] ? 4'b1110 : 4'b1111;
   assign spi_rbusy = m_busy;
   assign spi_wbusy = 1'b0;
   assign spi_rdata = m_rdata;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ctrl <= '0; m_imm <= '0; m_rdata <= '0; m_res <= '0; m_cmd <= '0; m_faddr <= '0;
         m_busy <= 1'b0; m_served <= 1'b0; m_cnt <= 0; m_xfers <= 0; m_idx <= 0;
      end else begin
         if (spi_select && spi_we != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
               if (spi_we[b] && spi_addr == 2'd2) m_ctrl[8*b +: 8] <= spi_wdata[8*b +: 8];
               if (spi_we[b] && spi_addr == 2'd1) m_imm[8*b +: 8] <= spi_wdata[8*b +: 8];
            end
         end
         if (!m_ctrl[24]) m_idx <= 0;
         if (!spi_rd) m_served <= 1'b0;
         if (m_busy) begin
            if (m_cnt == 0) begin
               m_busy   <= 1'b0;
               m_served <= 1'b1;
               m_rdata  <= m_res;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (spi_select && spi_rd && !m_served && spi_addr == 2'd0) begin
            m_busy  <= 1'b1;
            m_cnt   <= 5;
            m_xfers <= m_xfers + 1;
            if (m_ctrl[24]) begin
               m_idx <= m_idx + 1;
               if (m_idx == 0) begin
                  m_cmd   <= m_imm;
                  m_faddr <= m_imm[23:0];
                  m_res   <= 32'hFFFF_FFFF;
               end else begin
                  m_res <= flash_word(m_faddr + 24'(4 * (m_idx - 1)));
               end
            end else begin
               m_res <= 32'hFFFF_FFFF;
            end
         end
      end
   end

   // Output monitor: records every accepted word.
   logic [31:0] obs_mem [0:63];
   int          obs_n = 0;
   int          valid_cnt = 0;

   always @(posedge clk) begin
      if (reset_n && out_valid) valid_cnt <= valid_cnt + 1;
      if (reset_n && out_valid && out_ready) begin
         obs_mem[obs_n[5:0]] <= out_data;
         obs_n               <= obs_n + 1;
      end
   end

   logic [31:0] exp_q [$];
   int          obs_rd;
   int          n_checks, n_fail;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_words(input logic [23:0] a, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(flash_word(a + 24'(4 * i)));
   endtask

   task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
      flash_addr = a;
      len        = n;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int c = 0;
      while (done !== 1'b1 && c < 2000) begin
         tick();
         c++;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy at done"}, 32'(busy), 32'd1);
      tick();
      check({tag, " busy after done"}, 32'(busy), 32'd0);
      check({tag, " done pulse"}, 32'(done), 32'd0);
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) begin
         if (obs_rd < obs_n) begin
            check({tag, " word"}, obs_mem[obs_rd[5:0]], exp_q.pop_front());
            obs_rd++;
         end else begin
            check({tag, " word count"}, 32'(obs_n - obs_rd), 32'(exp_q.size()));
            exp_q.delete();
         end
      end
      check({tag, " extra words"}, 32'(obs_n - obs_rd), 32'd0);
      obs_rd = obs_n;
   endtask

   initial begin
      int   x0, v0, c;
      logic ok, ok2;
      logic [31:0] d0;
      n_checks = 0; n_fail = 0; obs_rd = 0;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      flash_addr = '0; len = '0;
      cpu_we = '0; cpu_rd = 1'b0; cpu_select = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_data", out_data, 32'h0);
      check("reset strobes", 32'({spi_we, spi_rd, spi_select}), 32'd0);
      reset_n = 1'b1;
      tick();

      // Basic two-word read.
      x0 = m_xfers;
      push_words(24'h001000, 2);
      pulse_start(24'h001000, 16'd2);
      wait_done("A");
      drain("A");
      check("A mosi cmd", m_cmd, 32'h0300_1000);
      check("A xfers", 32'(m_xfers - x0), 32'd3);
      check("A ss", 32'(m_ss), 32'hF);

      // Command only.
      x0 = m_xfers;
      v0 = valid_cnt;
      pulse_start(24'h000200, 16'd0);
      wait_done("B");
      check("B xfers", 32'(m_xfers - x0), 32'd1);
      check("B no valid", 32'(valid_cnt - v0), 32'd0);
      drain("B");

      // Back-pressure on word 1 of 3.
      out_ready = 1'b0;
      push_words(24'h002000, 3);
      pulse_start(24'h002000, 16'd3);
      c = 0;
      while (out_valid !== 1'b1 && c < 400) begin tick(); c++; end
      check("C first valid", 32'(out_valid), 32'd1);
      d0 = out_data; x0 = m_xfers; ok = 1'b1; ok2 = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (out_data !== d0 || out_valid !== 1'b1) ok = 1'b0;
         if (m_ss !== 4'b1110) ok2 = 1'b0;
      end
      check("C data stable", 32'(ok), 32'd1);
      check("C no sck", 32'(m_xfers - x0), 32'd0);
      check("C ss held", 32'(ok2), 32'd1);
      out_ready = 1'b1;
      wait_done("C");
      drain("C");

      // CPU read in flight at start, then CPU write stalled during the run.
      x0 = m_xfers;
      cpu_select = 1'b1; cpu_rd = 1'b1; cpu_addr = 2'd0;
      tick();
      push_words(24'h003000, 1);
      pulse_start(24'h003000, 16'd1);
      c = 1; ok = 1'b1;
      while (!(c >= 2 && cpu_rbusy === 1'b0) && c < 100) begin
         if (spi_rd !== 1'b1 || spi_we !== 4'h0 || spi_select !== 1'b1) ok = 1'b0;
         tick();
         c++;
      end
      check("D cpu passthrough", 32'(ok), 32'd1);
      check("D cpu xfer", 32'(m_xfers - x0), 32'd1);
      check("D cpu rdata", cpu_rdata, 32'hFFFF_FFFF);
      check("D seq waiting", 32'(busy), 32'd1);
      cpu_select = 1'b0; cpu_rd = 1'b0;
      tick();
      cpu_select = 1'b1; cpu_we = 4'hF; cpu_addr = 2'd3; cpu_wdata = 32'h1234_5678;
      c = 0; ok = 1'b1;
      while (done !== 1'b1 && c < 2000) begin
         tick();
         c++;
         if (cpu_wbusy !== 1'b1) ok = 1'b0;
      end
      check("D cpu wbusy stall", 32'(ok), 32'd1);
      check("D done", 32'(done), 32'd1);
      tick();
      check("D busy after", 32'(busy), 32'd0);
      check("D cpu released", 32'(cpu_wbusy), 32'd0);
      cpu_select = 1'b0; cpu_we = 4'h0;
      tick();
      drain("D");
      check("D xfers", 32'(m_xfers - x0), 32'd3);

      // Abort during word 2 of 8.
      x0 = m_xfers;
      push_words(24'h004000, 2);
      pulse_start(24'h004000, 16'd8);
      c = 0;
      while (obs_n == obs_rd && c < 400) begin tick(); c++; end
      abort = 1'b1;
      wait_done("E");
      abort = 1'b0;
      drain("E");
      check("E xfers", 32'(m_xfers - x0), 32'd3);

      // Reset in the middle of a READ, then a clean run.
      x0 = m_xfers;
      pulse_start(24'h005000, 16'd4);
      c = 0;
      while (!((m_xfers - x0) >= 2 && spi_rd === 1'b1) && c < 400) begin tick(); c++; end
      check("F reached read", 32'(spi_rd), 32'd1);
      reset_n = 1'b0;
      #1;
      check("F busy", 32'(busy), 32'd0);
      check("F out_valid", 32'(out_valid), 32'd0);
      check("F strobes", 32'({spi_we, spi_rd, spi_select}), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      obs_rd = obs_n;
      exp_q.delete();
      x0 = m_xfers;
      push_words(24'h006000, 2);
      pulse_start(24'h006000, 16'd2);
      wait_done("F");
      drain("F");
      check("F xfers", 32'(m_xfers - x0), 32'd3);
      check("F ss", 32'(m_ss), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
